muldiv_seq: RTL and testbench

Iterative sequencer for the RV32M multiply/divide instructions, sitting beside the single-cycle alu in the execute stage.
- Accepts one operation at a time through a start/busy/done handshake.
- Runs a shift-add multiply or a restoring divide, one bit per cycle, using one internal XLEN+1-bit add/sub step.
- Returns a registered result. Execute stalls while busy is high.

---
 rtl/muldiv_seq.sv | 158 +++++++++++++++
 tb/tb_muldiv_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer (shift-add multiply, restoring divide)
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiply and |op1|<|op2| divide skip the iteration phase.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic              spec_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] prod;

  // Operand decode at accept time
  logic            is_div, sgn1, sgn2, n1, n2, neg, ovf, spec;
  logic [XLEN-1:0] m1, m2, spec_val;

  assign is_div = op[2];
  assign sgn1   = is_div ? ~op[0] : (op[1:0] != 2'b11);
  assign sgn2   = is_div ? ~op[0] : ~op[1];
  assign n1     = sgn1 & op1[XLEN-1];
  assign n2     = sgn2 & op2[XLEN-1];
  assign m1     = n1 ? -op1 : op1;
  assign m2     = n2 ? -op2 : op2;
  // Remainder takes the dividend's sign; quotient and products take the XOR
  assign neg    = (is_div & op[1]) ? n1 : (n1 ^ n2);
  assign ovf    = is_div & ~op[0] & (op1 == MIN_NEG) & (op2 == '1);

  always_comb begin
    spec     = 1'b0;
    spec_val = '0;
    if (is_div & (op2 == '0)) begin
      spec     = 1'b1;
      spec_val = op[1] ? op1 : '1;
    end else if (ovf) begin
      spec     = 1'b1;
      spec_val = op[1] ? '0 : op1;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (!is_div & ((op1 == '0) | (op2 == '0))) begin
      spec     = 1'b1;
      spec_val = '0;
    end else if (is_div & (m1 < m2)) begin
      spec     = 1'b1;
      spec_val = op[1] ? op1 : '0;
    end
`endif
  end

  // Single XLEN+1-bit add/sub shared by both algorithms
  logic            div_q;
  logic [XLEN:0]   shifted, add_a, add_b, add_s;
  logic [2*XLEN-1:0] prod_nx;

  assign div_q   = op_q[2];
  assign shifted = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
  assign add_a   = div_q ? shifted : {1'b0, prod[2*XLEN-1:XLEN]};
  assign add_b   = {1'b0, b_q};
  assign add_s   = div_q ? (add_a - add_b) : (add_a + add_b);

  always_comb begin
    prod_nx = prod;
    if (div_q) begin
      if (!add_s[XLEN]) prod_nx = {add_s[XLEN-1:0], prod[XLEN-2:0], 1'b1};
      else              prod_nx = {shifted[XLEN-1:0], prod[XLEN-2:0], 1'b0};
    end else begin
      if (prod[0]) prod_nx = {add_s, prod[XLEN-1:1]};
      else         prod_nx = {1'b0, prod[2*XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] full;
  logic [XLEN-1:0]   div_sel, fix_val;

  assign full    = neg_q ? -prod : prod;
  assign div_sel = op_q[1] ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

  always_comb begin
    fix_val = '0;
    if (spec_q)              fix_val = prod[XLEN-1:0];
    else if (div_q)          fix_val = neg_q ? -div_sel : div_sel;
    else if (op_q[1:0] == 2'b00) fix_val = full[XLEN-1:0];
    else                     fix_val = full[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      spec_q <= 1'b0;
      b_q    <= '0;
      prod   <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op_q   <= op;
            b_q    <= m2;
            neg_q  <= spec ? 1'b0 : neg;
            spec_q <= spec;
            prod   <= {{XLEN{1'b0}}, spec ? spec_val : m1};
            cnt    <= '0;
            state  <= spec ? S_FIXUP : S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            prod <= prod_nx;
            if (cnt == CW'(XLEN-1)) begin
              cnt   <= '0;
              state <= S_FIXUP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_FIXUP: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            result <= fix_val;
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_CALC) || (state == S_FIXUP);
  assign done = (state == S_DONE) && !flush;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized self-checking bench for muldiv_seq against an arithmetic reference model
// Honors MULDIV_EARLY_OUT_EN for the expected latency.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush),
    .op(op), .op1(op1), .op2(op2),
    .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (o)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; p = p >>> 32; end
      3'd2: begin p = sa * ub; p = p >>> 32; end
      3'd3: begin p = ua * ub; p = p >> 32; end
      3'd4: p = (b == 0) ? -1 : sa / sb;
      3'd5: p = (b == 0) ? -1 : ua / ub;
      3'd6: p = (b == 0) ? sa : sa % sb;
      default: p = (b == 0) ? ua : ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    bit sgn;
    sgn = (o == 3'd4) || (o == 3'd6);
    if (o[2] && b == 0) return 2;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_EARLY_OUT_EN
    ma = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    mb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (!o[2] && (a == 0 || b == 0)) return 2;
    if (o[2] && ma < mb) return 2;
`else
    ma = 0;
    mb = 0;
    if (ma != mb) return 0;
`endif
    return 34;
  endfunction

  // One operation; restart_at/flush_at/rst_at are cycle offsets after accept (0 = unused)
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input int restart_at, input int flush_at, input int rst_at);
    int lat, done_cyc, done_cnt, busy_bad;
    logic exp_busy;
    logic [31:0] res_at_done;
    lat = exp_lat(o, a, b);
    done_cyc = -1;
    done_cnt = 0;
    busy_bad = 0;
    res_at_done = '0;
    @(negedge clk);
    op = o; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        op = 3'($urandom);
        op1 = $urandom;
        op2 = $urandom;
      end
      if (k == rst_at) begin
        reset_n = 1'b0;
        #1;
        check({tag, "/rst_busy"}, 64'(busy), 64'd0);
        check({tag, "/rst_done"}, 64'(done), 64'd0);
        check({tag, "/rst_result"}, 64'(result), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        last_res = '0;
        return;
      end
      exp_busy = (k < lat) && (flush_at == 0 || k <= flush_at);
      if (busy !== exp_busy) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = k;
          res_at_done = result;
        end
      end
      if (k == restart_at) begin
        start = 1'b1;
        op1 = $urandom;
        op2 = $urandom;
      end
      if (k == restart_at + 1) start = 1'b0;
      if (k == flush_at) flush = 1'b1;
      if (k == flush_at + 1) flush = 1'b0;
    end
    check({tag, "/busy_profile"}, 64'(busy_bad), 64'd0);
    if (flush_at != 0) begin
      check({tag, "/no_done"}, 64'(done_cnt), 64'd0);
      check({tag, "/result_kept"}, 64'(result), 64'(last_res));
    end else begin
      check({tag, "/done_cycle"}, 64'(done_cyc), 64'(lat));
      check({tag, "/done_pulses"}, 64'(done_cnt), 64'd1);
      check({tag, "/result"}, 64'(res_at_done), 64'(expv));
      check({tag, "/result_held"}, 64'(result), 64'(expv));
      last_res = expv;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("mul_7x-3",   3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0, 0);
    run_op("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0, 0);
    run_op("mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 0);
    run_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("div_-20_6",  3'd4, -32'd20, 32'd6, 32'hFFFF_FFFD, 0, 0, 0);
    run_op("rem_-20_6",  3'd6, -32'd20, 32'd6, 32'hFFFF_FFFE, 0, 0, 0);
    run_op("divu_-20_6", 3'd5, -32'd20, 32'd6, 32'h2AAA_AAA7, 0, 0, 0);
    run_op("remu_-20_6", 3'd7, -32'd20, 32'd6, 32'h0000_0002, 0, 0, 0);
    run_op("div_by0",    3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("remu_by0",   3'd7, 32'd5, 32'd0, 32'd5, 0, 0, 0);
    run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0);
    run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);
    run_op("mul_zero",   3'd0, 32'd0, 32'h1234, 32'd0, 0, 0, 0);
    run_op("divu_small", 3'd5, 32'd3, 32'd10, 32'd0, 0, 0, 0);
    run_op("rem_small",  3'd6, -32'd3, 32'd10, -32'd3, 0, 0, 0);

    run_op("restart",    3'd0, 32'd1234, 32'd5678, 32'd7006652, 5, 0, 0);
    run_op("flush",      3'd5, 32'd1000, 32'd7, 32'd142, 0, 10, 0);
    run_op("mid_reset",  3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 0, 0, 20);

    // start and flush together in IDLE: nothing accepted
    run_op("pre_sf", 3'd0, 32'd3, 32'd3, 32'd9, 0, 0, 0);
    @(negedge clk);
    op = 3'd0; op1 = 32'd11; op2 = 32'd13; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush/busy", 64'(busy), 64'd0);
    begin
      int dcnt;
      dcnt = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done === 1'b1) dcnt++;
      end
      check("start_flush/no_done", 64'(dcnt), 64'd0);
      check("start_flush/result", 64'(result), 64'd9);
    end

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, ref_res(ro, ra, rb), 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
